// File: rtl/weight_sram_pkg.sv
// Shared defaults, FSM state type and lane-merge helper for the weight SRAM.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package weight_sram_pkg;

  localparam int DEF_DATA_W = 512;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_LANE_W = 16;
  localparam int DEF_RD_LAT = 1;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MAX_W = 4096;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Lanes whose mask bit is set come from new_w, the rest from old_w.
  function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_W-1:0] mask,
                                                  input int               lane_w);
    logic [MAX_W-1:0] m;
    logic [11:0]      bi;
    logic [11:0]      li;
    m = old_w;
    for (int i = 0; i < MAX_W; i++) begin
      bi = 12'(i);
      li = 12'(i / lane_w);
      if (mask[li]) m[bi] = new_w[bi];
    end
    return m;
  endfunction

endpackage

// File: rtl/weight_sram_rd_pipe.sv
// RD_LAT-stage read-data pipeline with a valid bit per stage.
// Latency: RD_LAT cycles from vld_i to vld_o.
// Backpressure: none; one word accepted per cycle, output holds until next valid word.
module sram_rd_pipe #(
  parameter int DATA_W = 512,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] dat_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  // Shift valids every cycle; a stage only captures data when a valid word arrives,
  // so the last stage holds its value between completed reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) dat_q[s] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) dat_q[0] <= dat_i;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
      end
    end
  end

  assign vld_o = vld_q[RD_LAT-1];
  assign dat_o = dat_q[RD_LAT-1];

endmodule

// File: rtl/weight_sram_param.sv
// Lane-masked weight SRAM with post-reset zero clear; optional write->read
// forwarding under macro WEIGHT_SRAM_WR_FWD_EN. Latency: RD_LAT cycles read.
// Backpressure: none; user traffic ignored until ready, then one read+write per cycle.
module weight_sram_param
  import weight_sram_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int LANE_W = DEF_LANE_W,
  parameter  int RD_LAT = DEF_RD_LAT,
  localparam int AW     = $clog2(DEPTH),
  localparam int LANES  = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csb,
  input  logic              wsb,
  input  logic [LANES-1:0]  wmask,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ready
);

  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_addr_q, clr_addr_d;
  logic              clr_en;
  logic              usr_en;
  logic              wr_in_rng;
  logic              rd_in_rng;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_word;

  assign wr_in_rng = {1'b0, waddr} < DEPTH_EXT;
  assign rd_in_rng = {1'b0, raddr} < DEPTH_EXT;
  assign wr_fire   = usr_en & ~csb & ~wsb & wr_in_rng;
  assign rd_fire   = usr_en & ~csb;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  // Clear address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_addr_q <= '0;
    else     clr_addr_q <= clr_addr_d;
  end

  // Next state: walk the clear address, leave CLEAR after the last word; READY is terminal
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        if (clr_addr_q == LAST_ADDR) state_d = READY;
        else                         clr_addr_d = clr_addr_q + 1'b1;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    clr_en = (state_q == CLEAR);
    usr_en = (state_q == READY);
    ready  = usr_en;
  end

  // Single write port: zero-fill during clear, lane-masked user writes afterwards
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr_q] <= '0;
    end else if (wr_fire) begin
      mem[waddr] <= DATA_W'(lane_merge(MAX_W'(mem[waddr]), MAX_W'(wdata),
                                       MAX_W'(wmask), LANE_W));
    end
  end

  // Read word entering the pipe: out-of-range reads return zero; collisions see
  // the pre-write word unless forwarding is built in
  always_comb begin
    rd_word = '0;
    if (rd_in_rng) rd_word = mem[raddr];
`ifdef WEIGHT_SRAM_WR_FWD_EN
    if (wr_fire && rd_in_rng && (waddr == raddr)) begin
      rd_word = DATA_W'(lane_merge(MAX_W'(rd_word), MAX_W'(wdata),
                                   MAX_W'(wmask), LANE_W));
    end
`else
`endif
  end

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (rd_fire),
    .dat_i (rd_word),
    .vld_o (rvalid),
    .dat_o (rdata)
  );

`ifndef SYNTHESIS
  // Backdoor full-word preload for simulation.
  task automatic load_w(input int index, input logic [DATA_W-1:0] data);
    mem[AW'(index)] <= data;
  endtask

  // Print mem[lo..hi] in binary for simulation debug.
  task automatic dump(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) $display("mem[%0d] = %b", i, mem[AW'(i)]);
  endtask
`endif

endmodule

// File: tb/tb_weight_sram_param.sv
// Self-checking bench for weight_sram_param: directed scenarios plus random traffic
// compared against an array/queue reference model; a second DEPTH=48 instance
// covers out-of-range addressing.
module tb_weight_sram_param;

  localparam int DW    = 512;
  localparam int DEPTH = 64;
  localparam int LW    = 16;
  localparam int RDL   = 2;
  localparam int LN    = DW / LW;
  localparam int AW    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, csb, wsb, rvalid, ready;
  logic [LN-1:0] wmask;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rdata;

  logic          rst48, csb48, wsb48, rvalid48, ready48;
  logic [LN-1:0] wmask48;
  logic [AW-1:0] waddr48, raddr48;
  logic [DW-1:0] wdata48, rdata48;

  weight_sram_param #(.DATA_W(DW), .DEPTH(DEPTH), .LANE_W(LW), .RD_LAT(RDL)) u_dut (
    .clk(clk), .rst(rst), .csb(csb), .wsb(wsb), .wmask(wmask), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .ready(ready)
  );

  weight_sram_param #(.DATA_W(DW), .DEPTH(48), .LANE_W(LW), .RD_LAT(RDL)) u_dut48 (
    .clk(clk), .rst(rst48), .csb(csb48), .wsb(wsb48), .wmask(wmask48), .waddr(waddr48),
    .wdata(wdata48), .raddr(raddr48), .rdata(rdata48), .rvalid(rvalid48), .ready(ready48)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [LN-1:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int l = 0; l < LN; l++) if (m[l]) r[l*LW +: LW] = new_w[l*LW +: LW];
    return r;
  endfunction

  function automatic logic [DW-1:0] pat48(input int i);
    logic [31:0] s;
    s = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    return {16{s}};
  endfunction

  // ---------------- reference model for the DEPTH=64 instance ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] dat;
  } exp_t;

  logic [DW-1:0] m_mem [DEPTH];
  exp_t          exp_q[$];
  bit            m_ready = 1'b0;
  int            m_cnt   = 0;
  int            cyc     = 0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_rd;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      m_rdata = '0;
      exp_q.delete();
    end else if (!m_ready) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1'b1;
    end else if (!csb) begin
      m_rd = (int'(raddr) < DEPTH) ? m_mem[raddr] : '0;
`ifdef WEIGHT_SRAM_WR_FWD_EN
      if (!wsb && waddr == raddr && int'(waddr) < DEPTH) m_rd = merge_lanes(m_rd, wdata, wmask);
`endif
      exp_q.push_back('{due: cyc + RDL - 1, dat: m_rd});
      if (!wsb && int'(waddr) < DEPTH) m_mem[waddr] = merge_lanes(m_mem[waddr], wdata, wmask);
    end
    #1;
    chk("ready", DW'(ready), DW'(m_ready));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      m_rdata = exp_q[0].dat;
      void'(exp_q.pop_front());
      chk("rvalid_pulse", DW'(rvalid), DW'(1));
    end else begin
      chk("rvalid_idle", DW'(rvalid), DW'(0));
    end
    chk("rdata", rdata, m_rdata);
  end

  // ---------------- driving helpers ----------------
  task automatic drv(input bit c, input bit w, input int wa, input int ra,
                     input logic [LN-1:0] m, input logic [DW-1:0] d);
    @(negedge clk);
    csb = c; wsb = w; waddr = AW'(wa); raddr = AW'(ra); wmask = m; wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      csb = 1'b1; wsb = 1'b1;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, DW'(n), DW'(DEPTH));
  endtask

  // Issue one read (optionally with a write), measure latency to rvalid, check data.
  task automatic rd_check(input string tag, input int ra, input bit wr, input int wa,
                          input logic [LN-1:0] m, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp);
    int n;
    drv(1'b0, ~wr, wa, ra, m, d);
    n = 0;
    do begin
      @(posedge clk); #1;
      csb = 1'b1; wsb = 1'b1;
      n++;
    end while (!rvalid && n < 10);
    chk({tag, "_lat"}, DW'(n), DW'(RDL));
    chk({tag, "_dat"}, rdata, exp);
  endtask

  logic [DW-1:0] v_old, v_new, v_exp;
  logic [DW-1:0] w1, w2, w3;
  int            n48;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; csb = 1'b1; wsb = 1'b1; wmask = '0; waddr = '0; raddr = '0; wdata = '0;
    rst48 = 1'b1; csb48 = 1'b1; wsb48 = 1'b1; wmask48 = '0; waddr48 = '0; raddr48 = '0; wdata48 = '0;

    // Reset state and clear length
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, '0);
    chk("rst_ready", DW'(ready), DW'(0));
    rst = 1'b0;
    wait_ready("ready_after_boot");

    // Every word reads back zero after the clear
    for (int a = 0; a < DEPTH; a++) drv(1'b0, 1'b1, 0, a, '0, '0);
    idle(4);

    // Full write then lane-0-only overwrite of address 5
    drv(1'b0, 1'b0, 5, 0, '1, {64{8'hA5}});
    drv(1'b0, 1'b0, 5, 0, LN'(1), '1);
    idle(2);
    v_exp = {64{8'hA5}};
    v_exp[15:0] = 16'hFFFF;
    rd_check("mask_lane0", 5, 1'b0, 0, '0, '0, v_exp);
    idle(2);

    // Back-to-back reads of 1,2,3
    w1 = rand_word(); w2 = rand_word(); w3 = rand_word();
    drv(1'b0, 1'b0, 1, 0, '1, w1);
    drv(1'b0, 1'b0, 2, 0, '1, w2);
    drv(1'b0, 1'b0, 3, 0, '1, w3);
    drv(1'b0, 1'b1, 0, 1, '0, '0);
    drv(1'b0, 1'b1, 0, 2, '0, '0);
    drv(1'b0, 1'b1, 0, 3, '0, '0);
    idle(4);

    // Same-cycle write and read of address 7
    v_old = rand_word(); v_new = rand_word();
    drv(1'b0, 1'b0, 7, 0, '1, v_old);
    idle(1);
`ifdef WEIGHT_SRAM_WR_FWD_EN
    v_exp = v_new;
`else
    v_exp = v_old;
`endif
    rd_check("collide7", 7, 1'b1, 7, '1, v_new, v_exp);
    idle(2);

    // Reset during clear cycle 30
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_ready("ready_after_midclear_rst");

    // Reset with a read in flight
    drv(1'b0, 1'b1, 0, 3, '0, '0);
    @(negedge clk); csb = 1'b1; rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("inflight_no_rvalid", DW'(rvalid), DW'(0));
    end
    @(negedge clk); rst = 1'b0;
    wait_ready("ready_after_inflight_rst");

    // Random traffic with a narrow address range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      drv(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1),
          ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1),
          LN'($urandom), rand_word());
    end
    idle(5);

    // DEPTH=48 instance: out-of-range write dropped, read returns zero with rvalid
    @(negedge clk); rst48 = 1'b0;
    n48 = 0;
    while (!ready48 && n48 < 200) begin
      @(posedge clk); #1;
      n48++;
    end
    chk("d48_ready", DW'(n48), DW'(48));
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      csb48 = 1'b0; wsb48 = 1'b0; waddr48 = AW'(i); raddr48 = '0; wmask48 = '1; wdata48 = pat48(i);
    end
    @(negedge clk);
    csb48 = 1'b0; wsb48 = 1'b0; waddr48 = AW'(50); raddr48 = AW'(50); wmask48 = '1; wdata48 = '1;
    @(negedge clk); csb48 = 1'b1; wsb48 = 1'b1;
    @(posedge clk); #1;
    chk("d48_oor_rvalid", DW'(rvalid48), DW'(1));
    chk("d48_oor_rdata", rdata48, '0);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk); csb48 = 1'b0; raddr48 = AW'(i);
      @(negedge clk); csb48 = 1'b1;
      @(posedge clk); #1;
      chk("d48_keep_rvalid", DW'(rvalid48), DW'(1));
      chk("d48_keep_rdata", rdata48, pat48(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
